// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// State encoding and word geometry used by the loader and its byte packer.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte assembler; o_word is valid combinationally with the 4th accepted byte.
// No backpressure of its own: every i_vld cycle consumes i_dat, partial bytes hold while idle.
module byte_packer
  import riscv_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        i_vld,
  input  logic [7:0]  i_dat,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;

  // Bytes shift in from the top so the first byte lands in bits [7:0].
  assign o_word     = {i_dat, r_shift};
  assign o_word_vld = i_vld && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (i_vld) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {i_dat, r_shift[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 4-byte LE word-count header, then N LE words written to instruction RAM.
// 5 cycles per word back-to-back; in_ready drops during the write cycle and in DONE/ERR.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [31:0]           mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  core_clear,
  output logic                  done,
  output logic                  error
);

  ld_state_t             r_state, w_nxt;
  logic                  r_in_ready, r_mem_we, r_core_clear, r_done, r_error;
  logic [31:0]           r_mem_data, r_count, r_word_idx;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic        w_xfer, w_hdr_acc, w_pay_acc, w_hdr_vld, w_pay_vld, w_last;
  logic [31:0] w_hdr_word, w_pay_word;

  assign w_xfer    = in_valid && r_in_ready;
  assign w_hdr_acc = w_xfer && (r_state == ST_HDR);
  assign w_pay_acc = w_xfer && (r_state == ST_LOAD);
  assign w_last    = (r_word_idx == r_count - 32'd1);

  byte_packer u_hdr_packer (
    .clock      (clock),
    .clear      (clear),
    .i_vld      (w_hdr_acc),
    .i_dat      (in_data),
    .o_word     (w_hdr_word),
    .o_word_vld (w_hdr_vld)
  );

  byte_packer u_pay_packer (
    .clock      (clock),
    .clear      (clear),
    .i_vld      (w_pay_acc),
    .i_dat      (in_data),
    .o_word     (w_pay_word),
    .o_word_vld (w_pay_vld)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_HDR: begin
        if (w_hdr_vld) begin
          if (w_hdr_word == 32'd0)                 w_nxt = ST_DONE;
          else if (w_hdr_word > 32'(MAX_WORDS))    w_nxt = ST_ERR;
          else                                     w_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  if (w_pay_vld) w_nxt = ST_WRITE;
      ST_WRITE: w_nxt = w_last ? ST_DONE : ST_LOAD;
      ST_DONE:  w_nxt = ST_DONE;
      ST_ERR:   w_nxt = ST_ERR;
      default:  w_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) r_state <= ST_HDR;
    else       r_state <= w_nxt;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_core_clear <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_mem_data   <= '0;
      r_mem_addr   <= ADDR_WIDTH'(BASE_ADDR);
    end else begin
      r_in_ready   <= (w_nxt == ST_HDR) || (w_nxt == ST_LOAD);
      r_mem_we     <= (w_nxt == ST_WRITE);
      r_core_clear <= (w_nxt != ST_DONE);
      r_done       <= (w_nxt == ST_DONE);
      r_error      <= (w_nxt == ST_ERR);
      if (w_hdr_vld) r_count <= w_hdr_word;
      if (w_pay_vld) begin
        r_mem_data <= w_pay_word;
        r_mem_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_word_idx);
      end
      if ((r_state == ST_WRITE) && !w_last) r_word_idx <= r_word_idx + 32'd1;
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_data   = r_mem_data;
  assign mem_addr   = r_mem_addr;
  assign core_clear = r_core_clear;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected writes and timing are derived from the stream bytes.
module tb_imem_loader;

  localparam int MAXW = 4;
  localparam int BASE = 0;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        core_clear;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock      (clock),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_data   (mem_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .core_clear (core_clear),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cyc = -1;
  logic [7:0]  stim[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  bit          wr_ir[$];
  bit          wr_cc[$];
  int          xfer_cyc[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Passive monitor: records every accepted byte and every RAM write pulse.
  always @(negedge clock) begin
    cyc++;
    if (in_valid === 1'b1 && in_ready === 1'b1) xfer_cyc.push_back(cyc);
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      wr_cyc.push_back(cyc);
      wr_ir.push_back(in_ready);
      wr_cc.push_back(core_clear);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear(input int n);
    tick();
    clear = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    clear = 1'b0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    wr_ir.delete(); wr_cc.delete(); xfer_cyc.delete();
    done_cyc = -1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_core_clear", core_clear, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_data", mem_data, 0);
    @(negedge clock);
    chk("rst_ready_rise", in_ready, 1);
  endtask

  // gap < 0: random 0..2 idle cycles after each byte; otherwise a fixed gap.
  task automatic send(input int first, input int n, input int gap);
    int g, w;
    for (int i = first; i < first + n; i++) begin
      tick();
      in_valid = 1'b1;
      in_data  = stim[i];
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) begin
        chk("xfer_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(done || error) && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("end_reached", longint'(done || error), 1);
    tick();
  endtask

  // Reference: header N, then N LE words to BASE+i; write one cycle after the word's
  // last byte, done one cycle after the last write (or after the header when N==0).
  task automatic verify();
    logic [31:0] n;
    bit          ovs;
    int          nw, last;
    n   = {stim[3], stim[2], stim[1], stim[0]};
    ovs = (n > 32'(MAXW));
    nw  = ovs ? 0 : int'(n);
    chk("n_writes", wr_data.size(), nw);
    chk("n_xfers", xfer_cyc.size(), 4 + 4 * nw);
    for (int i = 0; i < nw && i < wr_data.size(); i++) begin
      chk("wr_addr", wr_addr[i], BASE + i);
      chk("wr_data", wr_data[i], {stim[4*i+7], stim[4*i+6], stim[4*i+5], stim[4*i+4]});
      if (xfer_cyc.size() > 4 * i + 7) chk("wr_cycle", wr_cyc[i], xfer_cyc[4*i+7] + 1);
      chk("wr_in_ready", wr_ir[i], 0);
      chk("wr_core_clear", wr_cc[i], 1);
    end
    chk("end_done", done, ovs ? 0 : 1);
    chk("end_error", error, ovs ? 1 : 0);
    chk("end_core_clear", core_clear, ovs ? 1 : 0);
    chk("end_in_ready", in_ready, 0);
    last = 4 * nw + 3;
    if (!ovs && xfer_cyc.size() > last)
      chk("done_cycle", done_cyc, xfer_cyc[last] + 1 + ((nw > 0) ? 1 : 0));
  endtask

  initial begin
    logic [31:0] n;
    int          nw;
    bit          bad;

    clear = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    do_clear(2);

    // Basic two-word load, back-to-back
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    send(0, stim.size(), 0);
    wait_end();
    verify();
    if (wr_cyc.size() == 2) chk("pulse_spacing", wr_cyc[1] - wr_cyc[0], 5);
    else chk("pulse_count", wr_cyc.size(), 2);
    chk("basic_w1", (wr_data.size() > 1) ? wr_data[1] : 32'h0, 32'h00100093);

    // Bytes offered after done are ignored
    tick();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (in_ready || mem_we || !done || core_clear) bad = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    chk("post_done_quiet", bad, 0);
    chk("post_done_xfers", xfer_cyc.size(), 12);
    chk("post_done_writes", wr_data.size(), 2);

    // Zero-length image
    do_clear(1);
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send(0, 4, 0);
    wait_end();
    verify();

    // Oversize header (MAXW+1) and its persistence
    do_clear(1);
    stim = '{8'h05, 8'h00, 8'h00, 8'h00};
    send(0, 4, 0);
    wait_end();
    verify();
    bad = 1'b0;
    in_valid = 1'b1;
    repeat (100) begin
      @(negedge clock);
      if (!error || !core_clear || in_ready || mem_we || done) bad = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    chk("err_persist", bad, 0);
    chk("err_no_write", wr_data.size(), 0);

    // Valid toggling on the payload
    do_clear(1);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(0, 4, 0);
    send(4, 4, 1);
    wait_end();
    verify();
    chk("gap_word", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'hDEADBEEF);

    // Clear partway through the second word
    do_clear(1);
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'hAA, 8'hBB};
    send(0, 10, 0);
    repeat (3) tick();
    chk("mid_writes", wr_data.size(), 1);
    chk("mid_word", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'h11111111);
    do_clear(1);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22};
    send(0, 8, 0);
    wait_end();
    verify();
    chk("after_clear_word", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'h22222222);

    // Randomized images, including the MAXW boundary and oversize counts
    for (int t = 0; t < 10; t++) begin
      if (t == 0)                          n = 32'(MAXW);
      else if ($urandom_range(0, 3) == 0)  n = 32'(MAXW + 1) + ($urandom % 32'd5000) + (($urandom & 1) << 31);
      else                                 n = $urandom_range(0, MAXW);
      nw = (n > 32'(MAXW)) ? 0 : int'(n);
      stim.delete();
      for (int b = 0; b < 4; b++) stim.push_back(n[8*b +: 8]);
      for (int b = 0; b < 4 * nw; b++) stim.push_back(8'($urandom));
      do_clear(1 + int'($urandom_range(0, 1)));
      send(0, stim.size(), -1);
      wait_end();
      verify();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
